// File: rtl/bus_share.sv
// Shared-bus arbiter. N sources request the bus through active-low SRC_d bits.
// Owners take turns with a dead-cycle gap between them, and contended cycles are counted.
module bus_share #(
    parameter int W    = 16,
    parameter int N    = 5,
    parameter int TURN = 1,
    parameter int RR   = 0,
    parameter int WOR  = 0
) (
    input  logic             MCLK,
    input  logic             SRES,
    input  logic [N-1:0]     SRC_d,
    input  logic [N*W-1:0]   SRC_o,
    output logic [W-1:0]     BUS_o,
    output logic             BUS_d,
    output logic [N-1:0]     GNT,
    output logic             TURNING,
    output logic             CONT,
    output logic [7:0]       CONT_CNT
);

    localparam int IW = $clog2(N);
    localparam int CW = 4;

    typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

    state_t          state;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   last;
    logic [CW-1:0]   gap_cnt;
    logic [N-1:0]    req;
    logic [IW-1:0]   winner;
    int              req_count;
    logic            multi;

    assign req = ~SRC_d;

    // Scan from the far end toward the preferred index so the nearest requester wins.
    always_comb begin
        winner = '0;
        if (RR == 0) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (req[i]) winner = IW'(i);
            end
        end else begin
            for (int off = N; off >= 1; off--) begin
                if (req[(int'(last) + off) % N]) winner = IW'((int'(last) + off) % N);
            end
        end
    end

    always_comb begin
        req_count = 0;
        for (int i = 0; i < N; i++) begin
            req_count += int'(req[i]);
        end
    end

    assign multi   = (req_count >= 2);
    assign TURNING = (state == GAP);

    // Wired-OR mode bypasses the FSM entirely and merges every active driver.
    always_comb begin
        BUS_o = '0;
        BUS_d = 1'b1;
        if (WOR != 0) begin
            for (int i = 0; i < N; i++) begin
                if (req[i]) BUS_o = BUS_o | SRC_o[i*W +: W];
            end
            BUS_d = &SRC_d;
        end else if (state == DRIVE) begin
            BUS_o = SRC_o[int'(owner)*W +: W];
            BUS_d = 1'b0;
        end
    end

    always_ff @(posedge MCLK) begin
        if (!SRES) begin
            state    <= IDLE;
            GNT      <= '0;
            owner    <= '0;
            last     <= IW'(N - 1);
            gap_cnt  <= '0;
            CONT     <= 1'b0;
            CONT_CNT <= 8'd0;
        end else begin
            CONT <= multi;
            if (multi && CONT_CNT != 8'hFF) CONT_CNT <= CONT_CNT + 8'd1;

            if (WOR != 0) begin
                state <= IDLE;
                GNT   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (|req) begin
                            GNT   <= {{(N-1){1'b0}}, 1'b1} << winner;
                            owner <= winner;
                            last  <= winner;
                            state <= DRIVE;
                        end
                    end
                    DRIVE: begin
                        // Release is only ever voluntary: no other request can take the bus.
                        if (SRC_d[owner]) begin
                            GNT     <= '0;
                            gap_cnt <= CW'(TURN - 1);
                            state   <= GAP;
                        end
                    end
                    GAP: begin
                        if (gap_cnt == '0) state <= IDLE;
                        else               gap_cnt <= gap_cnt - 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/bus_share.md
BUS_SHARE -- requirements
Module: bus_share

Interface
REQ-001 SHALL have parameter W, default 16, data bus width (1..32).
REQ-002 SHALL have parameter N, default 5, number of drive sources (2..8).
REQ-003 SHALL have parameter TURN, default 1, dead cycles between owners (1..15).
REQ-004 SHALL have parameter RR, default 0, arbitration mode (0 = fixed priority with lowest index first, 1 = round-robin).
REQ-005 SHALL have parameter WOR, default 0; 1 selects legacy wired-OR mode (REQ-024).
REQ-006 SHALL have port MCLK, input, 1 bit, sole clock; all state changes on its rising edge.
REQ-007 SHALL have port SRES, input, 1 bit, reset; synchronous, active-low.
REQ-008 SHALL have port SRC_d, input, N bits; per-source drive request, 0 = request (codebase _d convention).
REQ-009 SHALL have port SRC_o, input, N*W bits; source k data occupies bits [k*W +: W].
REQ-010 SHALL have port BUS_o, output, W bits; shared bus data.
REQ-011 SHALL have port BUS_d, output, 1 bit; 1 = bus released/input, 0 = driven.
REQ-012 SHALL have port GNT, output, N bits; one-hot grant, registered.
REQ-013 SHALL have port TURNING, output, 1 bit; high during turnaround.
REQ-014 SHALL have port CONT, output, 1 bit; registered contention pulse.
REQ-015 SHALL have port CONT_CNT, output, 8 bits; saturating contention counter.

Function
REQ-016 SHALL implement states IDLE, DRIVE, GAP.
REQ-017 In IDLE, if any SRC_d bit is 0, SHALL select a winner per RR, load GNT and go to DRIVE on the next edge (1-cycle grant latency); otherwise SHALL stay in IDLE.
REQ-018 In RR=0 mode, the winner SHALL be the lowest-index requester.
REQ-019 In RR=1 mode, the winner SHALL be the first requester at an index above the last owner, wrapping modulo N; after reset, last owner SHALL be N-1, so the search starts at index 0.
REQ-020 In DRIVE, BUS_d SHALL be 0 and BUS_o SHALL equal the owner's SRC_o slice combinationally; arbitration SHALL be non-preemptive.
REQ-021 In DRIVE, when the owner's SRC_d bit is 1, the next edge SHALL clear GNT, load the gap counter with TURN-1, and enter GAP; the bus SHALL be released in that same edge.
REQ-022 In GAP, BUS_d SHALL be 1 and TURNING SHALL be 1; the counter SHALL decrement each cycle; at 0 the next edge SHALL enter IDLE, giving exactly TURN GAP cycles.
REQ-023 Outside DRIVE, BUS_o SHALL be all zeros and BUS_d SHALL be 1.
REQ-024 With WOR=1, the FSM SHALL be held in IDLE with GNT zero. BUS_o SHALL be the OR of the SRC_o slices whose SRC_d bit is 0. BUS_d SHALL be the AND of all SRC_d bits. Both SHALL be combinational, with no turnaround.
REQ-025 Contention SHALL be any cycle with 2 or more SRC_d bits at 0. CONT SHALL go high the cycle after such a cycle, for one cycle per contended cycle. CONT_CNT SHALL increment once per contended cycle and hold at 255.
REQ-026 Contention detection SHALL operate in both WOR modes.
REQ-027 A requester that releases before being granted SHALL be ignored; no request is latched.
REQ-028 If the owner's request is withdrawn and another source requests in the same cycle, SHALL still pass through GAP and IDLE; the new grant SHALL occur no earlier than TURN+1 cycles later.

Reset
REQ-029 While SRES=0 at an edge, the block SHALL take the following values: state IDLE; GNT=0; BUS_d=1; BUS_o=0; TURNING=0; CONT=0; CONT_CNT=0; gap counter 0; RR last owner N-1.
REQ-030 Reset applied mid-DRIVE or mid-GAP SHALL release the bus at that edge, with no turnaround.
REQ-031 The first grant after reset release SHALL occur no earlier than one edge after SRES returns to 1.

Verification
REQ-032 Fixed priority (W=16, N=5, TURN=1, RR=0): SRC_d=5'b11001, SRC_o[1]=16'h1234, SRC_o[2]=16'h5678 -> GNT=5'b00010 one cycle later; BUS_o=16'h1234; BUS_d=0; CONT pulses once per cycle; CONT_CNT increments.
REQ-033 Turnaround (TURN=3): owner 1 releases while source 3 requests -> 3 cycles with TURNING=1 and BUS_d=1, then 1 IDLE cycle, then GNT=5'b01000.
REQ-034 Round-robin (RR=1): all 5 sources request continuously, each releasing after 2 DRIVE cycles -> grant order 0,1,2,3,4,0.
REQ-035 Legacy (WOR=1): SRC_d=5'b11100, slices 0/1 = 16'h00F0/16'h0F00 -> BUS_o=16'h0FF0, BUS_d=0 same cycle; SRC_d=5'b11111 -> BUS_d=1, BUS_o=0.
REQ-036 Saturation and reset: 300 contended cycles -> CONT_CNT=255; SRES=0 for one edge mid-DRIVE -> BUS_d=1, GNT=0, CONT_CNT=0 after that edge.
